// File: rtl/keypad_scan_if.sv
// Pin-side bundle for the keypad scanner: row sense in, column drive and debounced key state out.
// The scanner takes the master view; the board/encoder side takes the slave view.
interface keypad_scan_if;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] keys;
    logic        keys_chg;
    logic        frame_done;

    modport master (
        input  row_in,
        output col_out,
        output keys,
        output keys_chg,
        output frame_done
    );

    modport slave (
        output row_in,
        input  col_out,
        input  keys,
        input  keys_chg,
        input  frame_done
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 active-low matrix scanner with whole-frame debounce; keys valid one cycle after the final column tick.
// No backpressure: keys/keys_chg/frame_done are level/pulse outputs, consumer must keep up.
module keypad_scan #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    keypad_scan_if.master kp
);
    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB      = 4'(DEBOUNCE);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       col_q, col_d;
    logic [3:0]       col_out_q, col_out_d;
    logic [15:0]      frame_q, frame_d;
    logic [15:0]      prev_q, prev_d;
    logic [15:0]      keys_q, keys_d;
    logic [3:0]       stable_q, stable_d;
    logic             chg_q, chg_d;
    logic             fd_q, fd_d;
    logic             tick;

    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        col_d     = tick ? col_q + 2'd1 : col_q;
        col_out_d = ~(4'b0001 << col_d);
        frame_d   = frame_q;
        prev_d    = prev_q;
        stable_d  = stable_q;
        keys_d    = keys_q;
        chg_d     = 1'b0;
        fd_d      = 1'b0;

        if (tick) begin
            // Sample with the column that has been driven for the whole dwell.
            for (int r = 0; r < 4; r++) begin
                frame_d[{2'(r), col_q}] = ~kp.row_in[r];
            end
            if (col_q == 2'd3) begin
                fd_d   = 1'b1;
                prev_d = frame_d;
                if (frame_d == prev_q) begin
                    stable_d = (stable_q >= DEB) ? DEB : stable_q + 4'd1;
                end else begin
                    stable_d = 4'd1;
                end
                if ((stable_d == DEB) && (frame_d != keys_q)) begin
                    keys_d = frame_d;
                    chg_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            col_q     <= 2'd0;
            col_out_q <= 4'b1110;
            frame_q   <= '0;
            prev_q    <= '0;
            stable_q  <= '0;
            keys_q    <= '0;
            chg_q     <= 1'b0;
            fd_q      <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            col_q     <= col_d;
            col_out_q <= col_out_d;
            frame_q   <= frame_d;
            prev_q    <= prev_d;
            stable_q  <= stable_d;
            keys_q    <= keys_d;
            chg_q     <= chg_d;
            fd_q      <= fd_d;
        end
    end

    assign kp.col_out    = col_out_q;
    assign kp.keys       = keys_q;
    assign kp.keys_chg   = chg_q;
    assign kp.frame_done = fd_q;
endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 active-low key matrix and drives one column at a time.
- Debounces whole-matrix snapshots and produces the registered 16-bit one-hot-per-key vector `keys[15:0]`.
- That vector feeds the team's 16-input priority key encoder, which derives `key_in` and `key_val`.
- Sits between the board keypad pins and the encoder; it is the producer end of the `keys` bus.

Parameters:
- SCAN_DIV, 1000, clock cycles each column is driven before its rows are sampled (>=2).
- DEBOUNCE, 4, number of consecutive identical frames required before `keys` updates (>=1, <=15).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- row_in  input  4  matrix rows, active-low (pulled up externally); `row_in[r]` low = key in row r of driven column closed.
- col_out  output  4  column drive, active-low one-hot; exactly one bit low at all times.
- keys  output  16  debounced key state, 1 = pressed; bit index = 4*row + col.
- keys_chg  output  1  one-cycle pulse when `keys` takes a new, different value.
- frame_done  output  1  one-cycle pulse at the end of every 4-column frame.

Behaviour:
- Reset (`rst_n` low at a clk edge), regardless of state:
  - div_cnt=0, col=0, `col_out`=4'b1110.
  - frame buffer=0, prev_frame=0, stable_cnt=0.
  - `keys`=0, `keys_chg`=0, `frame_done`=0.
  - Reset mid-frame discards the partial frame; scanning restarts at column 0 with a full SCAN_DIV dwell.
- Divider:
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - tick = (div_cnt==SCAN_DIV-1), a combinational single-cycle strobe.
- Column drive:
  - `col_out` = ~(4'b0001 << col), registered from col.
  - On tick: col <= col+1, wrapping mod 4 (3 -> 0).
  - Sampling happens at the end of each dwell, giving SCAN_DIV-1 cycles of settle time.
- Sampling: on tick, for r=0..3, frame[4*r+col] <= ~row_in[r], using the current (pre-increment) col.
- Frame evaluation on a tick with col==3:
  - next_frame = frame with column-3 bits replaced by this cycle's samples, formed combinationally.
  - If next_frame == prev_frame: stable_cnt <= min(stable_cnt+1, DEBOUNCE).
  - Otherwise: stable_cnt <= 1.
  - prev_frame <= next_frame.
  - If the updated stable_cnt == DEBOUNCE and next_frame != `keys`: `keys` <= next_frame and `keys_chg` <= 1 for exactly one cycle.
  - `frame_done` <= 1 for exactly one cycle.
  - All three outputs are visible in the cycle after the final tick.
- Latency:
  - One frame = 4*SCAN_DIV cycles; the first frame ends at the edge closing cycle 4*SCAN_DIV-1 after reset release.
  - A press held stable across DEBOUNCE full frames appears in `keys` at the end of the DEBOUNCE-th frame.
  - A press arriving mid-frame makes that frame partial and different, so it counts as frame 1 only if all its columns were already sampled as pressed; otherwise full latency is DEBOUNCE+1 frames.
  - Releases follow the same rule.
- DEBOUNCE=1: every frame differing from `keys` is applied immediately.
- Bounce: any frame differing from its predecessor resets stable_cnt to 1, so `keys` holds its old value.
- Multiple keys: all pressed bits are reported. No ghost suppression; the priority encoder downstream resolves.
- All-released idle: frames of zeros saturate stable_cnt. `keys` stays 0 and `keys_chg` never fires.
- `keys` and `col_out` are registered and glitch-free. `row_in` must be synchronised by the top level before use; this block applies no synchroniser.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE=3, so one frame = 16 cycles.
- Reset, then hold `row_in`=4'hF for 64 cycles -> `col_out` sequence 1110,1101,1011,0111 repeating every 4 cycles; `frame_done` pulses every 16 cycles; `keys`=0; `keys_chg` never high.
- Model key row1/col2: `row_in[1]`=0 only while `col_out`=1011, applied from reset release -> `keys`=16'h0040 after 3rd frame_done; one `keys_chg` pulse; stays 16'h0040.
- Continuing the previous scenario, release the key -> `keys`=16'h0000 exactly 3 frames after the first all-released frame; single `keys_chg` pulse.
- Bounce the same key, toggling every 10 cycles for 100 cycles -> `keys` remains 0; no `keys_chg`.
- Hold row0/col0 and row3/col3 together -> `keys`=16'h8001 after 3 frames.
- Assert `rst_n`=0 for 1 cycle mid-frame while `keys`=16'h0040 -> next cycle `keys`=0 and `col_out`=1110; rescan re-reports 16'h0040 after 3 frames.
